// File: rtl/fpdiv_sched_pkg.sv
// fpdiv_sched_pkg: shared types and constants for the fpdiv_sched divider scheduler.
package fpdiv_sched_pkg;
    typedef enum logic [1:0] {IDLE, START, BUSY, RESP} state_e;

    typedef struct packed {
        logic [63:0] op1;
        logic [63:0] op2;
        logic [2:0]  rm;
        logic        op_type;
        logic        P;
    } req_t;

    typedef struct packed {
        logic [63:0] result;
        logic [4:0]  flags;
        logic        denorm;
        logic        timeout;
    } rsp_t;

    localparam logic [63:0] QNAN64 = 64'h7FF8000000000000;
endpackage

// File: rtl/fpdiv_sched_if.sv
// fpdiv_sched_if: requester, response and divider-side signals of fpdiv_sched.
interface fpdiv_sched_if;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [63:0] req0_op1, req0_op2, req1_op1, req1_op2;
    logic [2:0]  req0_rm, req1_rm;
    logic        req0_op_type, req1_op_type, req0_P, req1_P;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [63:0] rsp0_result, rsp1_result;
    logic [4:0]  rsp0_flags, rsp1_flags;
    logic        rsp0_denorm, rsp1_denorm, rsp0_timeout, rsp1_timeout;
    logic        OvEn, UnEn, div_OvEn, div_UnEn;
    logic        div_start;
    logic [63:0] div_op1, div_op2;
    logic [2:0]  div_rm;
    logic        div_op_type, div_P;
    logic        div_done;
    logic [63:0] div_result;
    logic [4:0]  div_flags;
    logic        div_denorm;

    modport master (
        output req0_valid, req0_op1, req0_op2, req0_rm, req0_op_type, req0_P,
        output req1_valid, req1_op1, req1_op2, req1_rm, req1_op_type, req1_P,
        output rsp0_ready, rsp1_ready, OvEn, UnEn,
        output div_done, div_result, div_flags, div_denorm,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_result, rsp0_flags, rsp0_denorm, rsp0_timeout,
        input  rsp1_valid, rsp1_result, rsp1_flags, rsp1_denorm, rsp1_timeout,
        input  div_start, div_op1, div_op2, div_rm, div_op_type, div_P, div_OvEn, div_UnEn
    );

    modport slave (
        input  req0_valid, req0_op1, req0_op2, req0_rm, req0_op_type, req0_P,
        input  req1_valid, req1_op1, req1_op2, req1_rm, req1_op_type, req1_P,
        input  rsp0_ready, rsp1_ready, OvEn, UnEn,
        input  div_done, div_result, div_flags, div_denorm,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_result, rsp0_flags, rsp0_denorm, rsp0_timeout,
        output rsp1_valid, rsp1_result, rsp1_flags, rsp1_denorm, rsp1_timeout,
        output div_start, div_op1, div_op2, div_rm, div_op_type, div_P, div_OvEn, div_UnEn
    );
endinterface

// File: rtl/fpdiv_sched_arb.sv
// fpdiv_rr_arb2: 2-way round-robin arbiter; favours the requester not granted last.
module fpdiv_rr_arb2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);
    logic last_q, last_d;

    // last_q resets to 1 so requester 0 wins the first tie
    assign grant[0] = req[0] & (~req[1] | last_q);
    assign grant[1] = req[1] & (~req[0] | ~last_q);
    assign last_d   = advance ? grant[1] : last_q;

    always_ff @(posedge clk) begin
        if (!reset_n) last_q <= 1'b1;
        else last_q <= last_d;
    end
endmodule

// File: rtl/fpdiv_sched.sv
// fpdiv_sched: shares one FP divider between two requesters with round-robin arbitration.
// Define FPDIV_SCHED_TIMEOUT_EN to add a BUSY watchdog that answers with a quiet NaN.
module fpdiv_sched
    import fpdiv_sched_pkg::*;
#(
    parameter int START_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    fpdiv_sched_if.slave bus
);
    state_e     state_q, state_d;
    req_t       req_q, req_d;
    req_t [1:0] req_in;
    rsp_t [1:0] rsp_q, rsp_d;
    logic       owner_q, owner_d;
    logic [2:0] cnt_q, cnt_d;
    logic       done_q, done_edge, tmo_hit, accept;
    logic [1:0] grant;

    fpdiv_rr_arb2 u_arb (
        .clk    (clk),
        .reset_n(reset_n),
        .req    ({bus.req1_valid, bus.req0_valid}),
        .advance(accept),
        .grant  (grant)
    );

    assign req_in[0] = {bus.req0_op1, bus.req0_op2, bus.req0_rm, bus.req0_op_type, bus.req0_P};
    assign req_in[1] = {bus.req1_op1, bus.req1_op2, bus.req1_rm, bus.req1_op_type, bus.req1_P};
    assign accept    = reset_n && state_q == IDLE && |grant;
    assign done_edge = bus.div_done & ~done_q;

`ifdef FPDIV_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q, tmo_d;

    assign tmo_d   = (state_q == BUSY) ? tmo_q + 1'b1 : '0;
    assign tmo_hit = state_q == BUSY && tmo_q == TW'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk) begin
        if (!reset_n) tmo_q <= '0;
        else tmo_q <= tmo_d;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        rsp_d   = rsp_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (accept) begin
                state_d = START;
                owner_d = grant[1];
                req_d   = req_in[grant[1]];
                cnt_d   = '0;
            end
            // a done edge wins over both the start count and the watchdog
            START, BUSY: if (done_edge) begin
                state_d        = RESP;
                rsp_d[owner_q] = '{bus.div_result, bus.div_flags, bus.div_denorm, 1'b0};
            end else if (tmo_hit) begin
                state_d        = RESP;
                rsp_d[owner_q] = '{QNAN64, 5'd0, 1'b0, 1'b1};
            end else if (state_q == START) begin
                state_d = (cnt_q == 3'(START_CYCLES - 1)) ? BUSY : START;
                cnt_d   = cnt_q + 3'd1;
            end
            RESP: if (owner_q ? bus.rsp1_ready : bus.rsp0_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            req_q   <= '0;
            rsp_q   <= '0;
            owner_q <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            rsp_q   <= rsp_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            done_q  <= bus.div_done;
        end
    end

    assign bus.req0_ready   = accept & grant[0];
    assign bus.req1_ready   = accept & grant[1];
    assign bus.rsp0_valid   = state_q == RESP && !owner_q;
    assign bus.rsp1_valid   = state_q == RESP && owner_q;
    assign bus.rsp0_result  = rsp_q[0].result;
    assign bus.rsp0_flags   = rsp_q[0].flags;
    assign bus.rsp0_denorm  = rsp_q[0].denorm;
    assign bus.rsp0_timeout = rsp_q[0].timeout;
    assign bus.rsp1_result  = rsp_q[1].result;
    assign bus.rsp1_flags   = rsp_q[1].flags;
    assign bus.rsp1_denorm  = rsp_q[1].denorm;
    assign bus.rsp1_timeout = rsp_q[1].timeout;
    assign bus.div_start    = state_q == START;
    assign bus.div_op1      = req_q.op1;
    assign bus.div_op2      = req_q.op2;
    assign bus.div_rm       = req_q.rm;
    assign bus.div_op_type  = req_q.op_type;
    assign bus.div_P        = req_q.P;
    assign bus.div_OvEn     = bus.OvEn;
    assign bus.div_UnEn     = bus.UnEn;
endmodule

// File: doc/fpdiv_sched.md
FPDIV_SCHED -- requirements
Module: fpdiv_sched

Interface
REQ-001 Parameter START_CYCLES, default 2: cycles div_start is held high per operation (1..7).
REQ-002 Parameter TIMEOUT_CYCLES, default 32: watchdog limit in BUSY (used only with FPDIV_SCHED_TIMEOUT_EN).
REQ-003 Clock and reset are fixed as follows:
- clk  in  1  sole clock; all state updates on the rising edge.
- reset_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 Requester ports, where N is 0 or 1:
- reqN_valid  in  1  request present.
- reqN_ready  out  1  request accepted this cycle.
- reqN_op1, reqN_op2  in  64  operands.
- reqN_rm  in  3  rounding mode.
- reqN_op_type  in  1  operation type.
- reqN_P  in  1  precision.
REQ-005 Response ports, where N is 0 or 1:
- rspN_valid  out  1  result available.
- rspN_ready  in  1  result consumed.
- rspN_result  out  64  quotient.
- rspN_flags  out  5  IEEE flags.
- rspN_denorm  out  1  denormal indicator.
- rspN_timeout  out  1  watchdog fired.
REQ-006 Global and divider-side ports:
- OvEn, UnEn  in  1 each  trap enables, forwarded unchanged to div_OvEn/div_UnEn.
- div_start  out  1  start to the divider.
- div_op1, div_op2  out  64  operands to the divider.
- div_rm  out  3  rounding mode to the divider.
- div_op_type  out  1  operation type to the divider.
- div_P  out  1  precision to the divider.
- div_done  in  1  divider done.
- div_result  in  64  divider result.
- div_flags  in  5  divider flags.
- div_denorm  in  1  divider denormal indicator.

Function
REQ-007 The FSM SHALL have states IDLE, START, BUSY and RESP.
REQ-008 In IDLE, reqN_ready SHALL be 1 only for the requester that the round-robin grant selects among asserted reqN_valid; both ready signals SHALL be 0 in every other state.
REQ-009 When both requesters are valid in IDLE, the requester not served last SHALL win; after reset, requester 0 SHALL win.
REQ-010 On acceptance (valid&ready in cycle T), the block SHALL latch the operands, rm, op_type, P and the owner ID, then go to START; div_* operand outputs SHALL hold the latched values until the next acceptance.
REQ-011 div_start SHALL be high in cycles T+1 through T+START_CYCLES exactly, then the FSM SHALL go to BUSY.
REQ-012 A rising edge of div_done (div_done=1 and previous div_done=0) seen in START or BUSY SHALL capture div_result, div_flags and div_denorm into the owner's response registers and move the FSM to RESP.
REQ-013 div_done SHALL be ignored in IDLE and RESP, and a constant-high div_done SHALL NOT retrigger a capture.
REQ-014 In RESP, rsp<owner>_valid SHALL stay high with stable data until rsp<owner>_ready=1; that cycle the FSM SHALL return to IDLE, and a new acceptance is possible from the next cycle.
REQ-015 Only the owner's response port SHALL ever be valid; the other rspN_valid SHALL stay 0.
REQ-016 Best-case cycles from acceptance to rsp_valid = START_CYCLES + divider latency + 1.

Reset
REQ-017 While reset_n=0, the FSM SHALL go to IDLE, the round-robin pointer SHALL select requester 0, the edge register SHALL clear, and div_start, reqN_ready, rspN_valid and rspN_timeout SHALL all be 0.
REQ-018 While reset_n=0, div_op*, div_rm, div_op_type, div_P, rspN_result, rspN_flags and rspN_denorm SHALL all be 0.
REQ-019 Reset asserted in any state, including mid-operation, SHALL abort the operation without emitting a response; a late div_done SHALL then be ignored per REQ-013.

Configuration
REQ-020 With FPDIV_SCHED_TIMEOUT_EN defined, a counter SHALL clear on entry to BUSY and increment each BUSY cycle; on reaching TIMEOUT_CYCLES without a done edge, the block SHALL enter RESP with result 64'h7FF8000000000000, flags 0, denorm 0 and rspN_timeout=1.
REQ-021 On a timeout, if a done edge coincides with the limit cycle, the done capture SHALL win over the timeout.
REQ-022 With FPDIV_SCHED_TIMEOUT_EN undefined, no counter SHALL exist, rspN_timeout SHALL be constant 0, and BUSY SHALL wait indefinitely.

Structure
REQ-023 Package fpdiv_sched_pkg SHALL hold the state enum, the request struct (op1, op2, rm, op_type, P), the response struct (result, flags, denorm, timeout) and constant QNAN64.
REQ-024 Arbitration SHALL be the sub-module fpdiv_rr_arb2 (2-way round-robin: inputs req[1:0] and advance, outputs one-hot grant[1:0]).

Verification
REQ-025 A bench SHALL cover these scenarios:
- Single request: req0 with op1=3FF0000000000000, op2=4000000000000000, rm=100, and a model that raises done 10 cycles after start falls -> div_start high for exactly 2 cycles; rsp0_result=3FE0000000000000, rsp0_valid held until rsp0_ready.
- Contention: req0 and req1 valid in the same IDLE cycle after reset -> req0 served first, then req1; next simultaneous pair -> req1 served first.
- Backpressure: rsp1_ready held 0 for 5 cycles -> rsp1_valid and data stable; req0_ready stays 0 throughout.
- Mid-operation reset: reset_n=0 during BUSY -> all outputs 0; subsequent div_done pulse produces no response.
- Timeout: macro defined, TIMEOUT_CYCLES=8, div_done never rises -> RESP after 8 BUSY cycles with result 7FF8000000000000 and timeout=1.
- Stuck done: div_done held at 1 across two operations -> only rising edges capture, with exactly one response per accepted request.
